tilemap_vram_sched: RTL
=======================

TILEMAP_VRAM_SCHED -- requirements
Module: tilemap_vram_sched

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 4, number of tilemap layers (legal 1..6).
REQ-002 SHALL have parameter SLOT_CYCLES, default 8, ce_pix periods per fetch round (legal >= NUM_LAYERS+2).
REQ-003 SHALL have parameter RS_BASE, default 15'h7000, VRAM base of layer-0 rowscroll table.
REQ-004 SHALL have parameter RS_STRIDE, default 15'h0200, VRAM word offset between successive layer tables.
REQ-005 clk  in  1  clock; all state on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 ce_pix  in  1  pixel enable; at least 3 clk between consecutive pulses.
REQ-008 line_start  in  1  one-clk pulse per scanline.
REQ-009 layer_addr  in  NUM_LAYERS*15  per-layer tile word address; bit 0 ignored.
REQ-010 layer_y  in  NUM_LAYERS*9  per-layer rowscroll line index.
REQ-011 rs_en  in  NUM_LAYERS  per-layer rowscroll enable.
REQ-012 cpu_req / cpu_we  in  1 / 1  CPU access request / write qualifier.
REQ-013 cpu_addr / cpu_din  in  15 / 16  CPU word address / write data.
REQ-014 cpu_busy / cpu_dout  out  1 / 16  access in progress / read data.
REQ-015 vram_addr / vram_dout / vram_we  out  15 / 16 / 1  VRAM port; vram_din in 16, valid the clk after vram_addr.
REQ-016 layer_load  out  NUM_LAYERS  one-clk strobe: tile_index/tile_attrib valid for that layer.
REQ-017 tile_index / tile_attrib  out  16 / 16  latched even / odd tile words.
REQ-018 rowscroll  out  NUM_LAYERS*10  per-layer rowscroll value.

Function
REQ-019 Slot counter SHALL increment on ce_pix, wrap SLOT_CYCLES-1 -> 0; line_start SHALL force it to SLOT_CYCLES-1 and set rs_pending (line_start wins over coincident ce_pix).
REQ-020 In FETCH state, slot k < NUM_LAYERS: on ce_pix clk vram_addr <= {layer_addr[k][14:1],0}; clk+1 tile_index <= vram_din, vram_addr[0] <= 1; clk+2 tile_attrib <= vram_din, layer_load[k] high exactly one clk.
REQ-021 cpu_req with cpu_busy low SHALL be captured (we, addr, din) and raise cpu_busy next clk; cpu_req while busy SHALL be ignored.
REQ-022 Pending CPU access SHALL issue on ce_pix clk of slot NUM_LAYERS (vram_addr <= cpu_addr, vram_we high one clk if write, vram_dout <= din).
REQ-023 On ce_pix clk of slot NUM_LAYERS+1, cpu_dout <= vram_din (reads only; unchanged on writes) and cpu_busy SHALL fall.
REQ-024 FSM states FETCH, RS_ADDR, RS_DATA; FETCH -> RS_ADDR on ce_pix of slot SLOT_CYCLES-1 with rs_pending set, clearing rs_pending, layer index i <= 0.
REQ-025 RS_ADDR: if rs_en[i], vram_addr <= RS_BASE + i*RS_STRIDE + layer_y[i], go RS_DATA; else rowscroll[i] <= 0, advance i.
REQ-026 RS_DATA: rowscroll[i] <= vram_din[9:0], advance i; after i = NUM_LAYERS-1 return to FETCH.
REQ-027 Address arithmetic SHALL be 15-bit, wrapping modulo 2^15.
REQ-028 Outside FETCH, layer fetches and CPU issue SHALL be suppressed; slot counter keeps running; cpu_busy stays high until serviced in a later round.
REQ-029 line_start during RS_* SHALL set rs_pending; new pass starts at next eligible slot.
REQ-030 vram_we SHALL never assert outside REQ-022.

Reset
REQ-031 Reset SHALL clear slot, state (FETCH), rs_pending, cpu_busy, vram_we, vram_addr, vram_dout, cpu_dout, layer_load, tile_index, tile_attrib, rowscroll to 0.
REQ-032 Reset mid-access SHALL abort it: no VRAM write after reset asserts, cpu_busy 0 next clk.

Verification
REQ-033 NUM_LAYERS=4, layer_addr[2]=15'h1235, mem[1234]=AAAA, mem[1235]=5555 -> slot 2: addr 1234 then 1235, layer_load[2] one clk, index AAAA, attrib 5555.
REQ-034 CPU write 15'h0100=BEEF at slot 1 -> vram_we one clk in slot 4, busy falls slot 5; read back -> cpu_dout BEEF.
REQ-035 line_start, rs_en=4'b1011, layer_y[1]=9'h005, mem[7205]=03FF -> rowscroll[1]=3FF, rowscroll[2]=0, no VRAM access for layer 2.
REQ-036 CPU request issued during rowscroll pass -> busy held, access completes next FETCH round, data correct.
REQ-037 reset asserted clk after cpu_req write -> no vram_we, all outputs 0.
REQ-038 NUM_LAYERS=6, SLOT_CYCLES=8 -> six layer_load strobes per round, CPU in slot 6, slot wraps 7 -> 0.

Source files
------------

// File: rtl/tilemap_vram_sched.sv
// Time-slotted VRAM arbiter for a tilemap engine: per-pixel-round tile word fetches per layer,
// one CPU access slot, and a per-scanline rowscroll table pass.
module tilemap_vram_sched #(
    parameter int          NUM_LAYERS  = 4,
    parameter int          SLOT_CYCLES = 8,
    parameter logic [14:0] RS_BASE     = 15'h7000,
    parameter logic [14:0] RS_STRIDE   = 15'h0200
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce_pix,
    input  logic                    line_start,
    input  logic [NUM_LAYERS*15-1:0] layer_addr,
    input  logic [NUM_LAYERS*9-1:0] layer_y,
    input  logic [NUM_LAYERS-1:0]   rs_en,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [14:0]             cpu_addr,
    input  logic [15:0]             cpu_din,
    output logic                    cpu_busy,
    output logic [15:0]             cpu_dout,
    output logic [14:0]             vram_addr,
    output logic [15:0]             vram_dout,
    output logic                    vram_we,
    input  logic [15:0]             vram_din,
    output logic [NUM_LAYERS-1:0]   layer_load,
    output logic [15:0]             tile_index,
    output logic [15:0]             tile_attrib,
    output logic [NUM_LAYERS*10-1:0] rowscroll
);
    localparam int SLOT_W = $clog2(SLOT_CYCLES);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_CPU  = SLOT_W'(NUM_LAYERS);
    localparam logic [SLOT_W-1:0] SLOT_DONE = SLOT_W'(NUM_LAYERS + 1);
    localparam logic [2:0]        LAST_IDX  = 3'(NUM_LAYERS - 1);

    typedef enum logic [1:0] {FETCH, RS_ADDR, RS_DATA} state_t;

    state_t                  state_q, state_d;
    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic                    rs_pending_q, rs_pending_d;
    logic [2:0]              idx_q, idx_d;
    logic                    ph1_q, ph1_d, ph2_q, ph2_d;
    logic [2:0]              fl_q, fl_d;
    logic                    cpu_busy_q, cpu_busy_d;
    logic                    cpu_issued_q, cpu_issued_d;
    logic                    cpu_rdcap_q, cpu_rdcap_d;
    logic                    cpu_we_r_q, cpu_we_r_d;
    logic [14:0]             cpu_addr_r_q, cpu_addr_r_d;
    logic [15:0]             cpu_din_r_q, cpu_din_r_d;
    logic [15:0]             rd_buf_q, rd_buf_d;
    logic [14:0]             vram_addr_q, vram_addr_d;
    logic [15:0]             vram_dout_q, vram_dout_d;
    logic                    vram_we_q, vram_we_d;
    logic [15:0]             cpu_dout_q, cpu_dout_d;
    logic [NUM_LAYERS-1:0]   layer_load_q, layer_load_d;
    logic [15:0]             tile_index_q, tile_index_d;
    logic [15:0]             tile_attrib_q, tile_attrib_d;
    logic [NUM_LAYERS*10-1:0] rowscroll_q, rowscroll_d;
    logic                    ce_eff;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        rs_pending_d  = rs_pending_q;
        idx_d         = idx_q;
        ph1_d         = 1'b0;
        ph2_d         = 1'b0;
        fl_d          = fl_q;
        cpu_busy_d    = cpu_busy_q;
        cpu_issued_d  = cpu_issued_q;
        cpu_rdcap_d   = 1'b0;
        cpu_we_r_d    = cpu_we_r_q;
        cpu_addr_r_d  = cpu_addr_r_q;
        cpu_din_r_d   = cpu_din_r_q;
        rd_buf_d      = rd_buf_q;
        vram_addr_d   = vram_addr_q;
        vram_dout_d   = vram_dout_q;
        vram_we_d     = 1'b0;
        cpu_dout_d    = cpu_dout_q;
        layer_load_d  = '0;
        tile_index_d  = tile_index_q;
        tile_attrib_d = tile_attrib_q;
        rowscroll_d   = rowscroll_q;

        // line_start swallows a coincident ce_pix entirely
        ce_eff = ce_pix & ~line_start;
        if (line_start) begin
            slot_d       = SLOT_LAST;
            rs_pending_d = 1'b1;
        end else if (ce_pix) begin
            slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
        end

        if (ph1_q) begin
            tile_index_d = vram_din;
            vram_addr_d  = {vram_addr_q[14:1], 1'b1};
            ph2_d        = 1'b1;
        end
        if (ph2_q) begin
            tile_attrib_d = vram_din;
            for (int k = 0; k < NUM_LAYERS; k++)
                if (fl_q == 3'(k)) layer_load_d[k] = 1'b1;
        end

        if (cpu_req && !cpu_busy_q) begin
            cpu_busy_d   = 1'b1;
            cpu_we_r_d   = cpu_we;
            cpu_addr_r_d = cpu_addr;
            cpu_din_r_d  = cpu_din;
        end
        // Read data is held here so a later address change cannot corrupt it
        if (cpu_rdcap_q) rd_buf_d = vram_din;
        if (ce_eff && slot_q == SLOT_DONE && cpu_issued_q) begin
            if (!cpu_we_r_q) cpu_dout_d = rd_buf_q;
            cpu_busy_d   = 1'b0;
            cpu_issued_d = 1'b0;
        end

        case (state_q)
            FETCH: if (ce_eff) begin
                if (slot_q == SLOT_LAST && rs_pending_q) begin
                    state_d      = RS_ADDR;
                    rs_pending_d = 1'b0;
                    idx_d        = '0;
                end
                for (int k = 0; k < NUM_LAYERS; k++) begin
                    if (slot_q == SLOT_W'(k)) begin
                        vram_addr_d = layer_addr[k*15 +: 15] & 15'h7FFE;
                        ph1_d       = 1'b1;
                        fl_d        = 3'(k);
                    end
                end
                if (slot_q == SLOT_CPU && cpu_busy_q && !cpu_issued_q) begin
                    vram_addr_d  = cpu_addr_r_q;
                    vram_dout_d  = cpu_din_r_q;
                    vram_we_d    = cpu_we_r_q;
                    cpu_issued_d = 1'b1;
                    cpu_rdcap_d  = 1'b1;
                end
            end
            RS_ADDR, RS_DATA: begin
                for (int k = 0; k < NUM_LAYERS; k++) begin
                    if (idx_q == 3'(k)) begin
                        if (state_q == RS_ADDR && rs_en[k]) begin
                            vram_addr_d = RS_BASE + 15'(k) * RS_STRIDE
                                        + {6'd0, layer_y[k*9 +: 9]};
                        end else if (state_q == RS_ADDR) begin
                            rowscroll_d[k*10 +: 10] = '0;
                        end else begin
                            rowscroll_d[k*10 +: 10] = vram_din[9:0];
                        end
                    end
                end
                if (state_q == RS_ADDR && rs_en[idx_q]) begin
                    state_d = RS_DATA;
                end else if (idx_q == LAST_IDX) begin
                    state_d = FETCH;
                end else begin
                    state_d = RS_ADDR;
                    idx_d   = idx_q + 3'd1;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            slot_q        <= '0;
            rs_pending_q  <= 1'b0;
            idx_q         <= '0;
            ph1_q         <= 1'b0;
            ph2_q         <= 1'b0;
            fl_q          <= '0;
            cpu_busy_q    <= 1'b0;
            cpu_issued_q  <= 1'b0;
            cpu_rdcap_q   <= 1'b0;
            cpu_we_r_q    <= 1'b0;
            cpu_addr_r_q  <= '0;
            cpu_din_r_q   <= '0;
            rd_buf_q      <= '0;
            vram_addr_q   <= '0;
            vram_dout_q   <= '0;
            vram_we_q     <= 1'b0;
            cpu_dout_q    <= '0;
            layer_load_q  <= '0;
            tile_index_q  <= '0;
            tile_attrib_q <= '0;
            rowscroll_q   <= '0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            rs_pending_q  <= rs_pending_d;
            idx_q         <= idx_d;
            ph1_q         <= ph1_d;
            ph2_q         <= ph2_d;
            fl_q          <= fl_d;
            cpu_busy_q    <= cpu_busy_d;
            cpu_issued_q  <= cpu_issued_d;
            cpu_rdcap_q   <= cpu_rdcap_d;
            cpu_we_r_q    <= cpu_we_r_d;
            cpu_addr_r_q  <= cpu_addr_r_d;
            cpu_din_r_q   <= cpu_din_r_d;
            rd_buf_q      <= rd_buf_d;
            vram_addr_q   <= vram_addr_d;
            vram_dout_q   <= vram_dout_d;
            vram_we_q     <= vram_we_d;
            cpu_dout_q    <= cpu_dout_d;
            layer_load_q  <= layer_load_d;
            tile_index_q  <= tile_index_d;
            tile_attrib_q <= tile_attrib_d;
            rowscroll_q   <= rowscroll_d;
        end
    end

    // A write strobe already in flight is killed the moment reset rises
    assign vram_we     = vram_we_q & ~reset;
    assign vram_addr   = vram_addr_q;
    assign vram_dout   = vram_dout_q;
    assign cpu_busy    = cpu_busy_q;
    assign cpu_dout    = cpu_dout_q;
    assign layer_load  = layer_load_q;
    assign tile_index  = tile_index_q;
    assign tile_attrib = tile_attrib_q;
    assign rowscroll   = rowscroll_q;
endmodule
